capture_sequencer: RTL and testbench

- Sequences one logic-analyzer acquisition: arm, wait for trigger, run the timestamp counter, record channel transitions to sample memory, stop.
- Drives the run input of the timestamp counter and consumes its time value.
- Writes {timestamp, channel data} records to a single-port sample RAM.
- Sits between the host/config register block and the sample RAM.

---
 rtl/la_pkg.sv | 23 ++
 rtl/trigger_matcher.sv | 24 ++
 rtl/capture_sequencer.sv | 169 ++++++++++++++++
 tb/tb_capture_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/la_pkg.sv
// Shared types and helpers for the logic-analyzer capture path.
package la_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_e;

   // Width of one sample record: {timestamp, channel data}.
   function automatic int unsigned rec_width(input int unsigned time_length,
                                             input int unsigned channels);
      return time_length + channels;
   endfunction

   // Record limit decode: 0 selects the full RAM depth.
   function automatic int unsigned decode_limit(input int unsigned max_samples,
                                                input int unsigned addr_width);
      return (max_samples == 0) ? (32'd1 << addr_width) : max_samples;
   endfunction

endpackage

// File: rtl/trigger_matcher.sv
// Combinational trigger compare: level match on masked channels, plus a
// transition requirement on masked channels that have edge enabled.
module trigger_matcher #(
   parameter int unsigned CHANNELS = 8
) (
   input  logic [CHANNELS-1:0] i_data,
   input  logic [CHANNELS-1:0] i_prev,
   input  logic [CHANNELS-1:0] i_mask,
   input  logic [CHANNELS-1:0] i_value,
   input  logic [CHANNELS-1:0] i_edge,
   output logic                o_trig_c
);

   logic [CHANNELS-1:0] w_level_ok;
   logic [CHANNELS-1:0] w_edge_ok;
   logic [CHANNELS-1:0] w_bit_ok;

   // Per-bit qualification; unmasked bits always pass.
   assign w_level_ok = ~(i_data ^ i_value);
   assign w_edge_ok  = ~i_edge | (i_data ^ i_prev);
   assign w_bit_ok   = ~i_mask | (w_level_ok & w_edge_ok);
   assign o_trig_c   = &w_bit_ok;

endmodule

// File: rtl/capture_sequencer.sv
// Acquisition sequencer: arm, wait for trigger, record channel transitions
// with timestamps into sample RAM, stop on abort, limit or timestamp saturation.
module capture_sequencer
   import la_pkg::*;
#(
   parameter int unsigned CHANNELS    = 8,
   parameter int unsigned TIME_LENGTH = 24,
   parameter int unsigned ADDR_WIDTH  = 10
) (
   input  logic                                        i_clk,
   input  logic                                        i_rst,
   input  logic                                        i_arm,
   input  logic                                        i_abort,
   input  logic [CHANNELS-1:0]                         i_data,
   input  logic [CHANNELS-1:0]                         i_trig_mask,
   input  logic [CHANNELS-1:0]                         i_trig_value,
   input  logic [CHANNELS-1:0]                         i_trig_edge,
   input  logic [ADDR_WIDTH:0]                         i_max_samples,
   input  logic [TIME_LENGTH-1:0]                      i_time,
   output logic                                        o_run,
   output logic                                        o_wr_en,
   output logic [ADDR_WIDTH-1:0]                       o_wr_addr,
   output logic [rec_width(TIME_LENGTH, CHANNELS)-1:0] o_wr_data,
   output logic [ADDR_WIDTH:0]                         o_count,
   output logic                                        o_busy,
   output logic                                        o_done,
   output logic                                        o_timeout
);

   localparam int unsigned REC_W = rec_width(TIME_LENGTH, CHANNELS);
   localparam int unsigned CNT_W = ADDR_WIDTH + 1;

   state_e             r_state, w_state;
   logic [CHANNELS-1:0] r_prev;
   logic [CNT_W-1:0]   r_limit, w_limit;
   logic [CNT_W-1:0]   r_count, w_count;
   logic               r_wr_en, w_wr_en;
   logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr;
   logic [REC_W-1:0]   r_wr_data, w_wr_data;
   logic               r_run, w_run;
   logic               r_busy, w_busy;
   logic               r_done, w_done;
   logic               r_timeout, w_timeout;

   logic               w_trig;
   logic               w_changed;
   logic               w_time_sat;
   logic [CNT_W-1:0]   w_limit_in;
   logic [CNT_W-1:0]   w_count_inc;

   trigger_matcher #(
      .CHANNELS (CHANNELS)
   ) u_trigger_matcher (
      .i_data   (i_data),
      .i_prev   (r_prev),
      .i_mask   (i_trig_mask),
      .i_value  (i_trig_value),
      .i_edge   (i_trig_edge),
      .o_trig_c (w_trig)
   );

   assign w_changed   = (i_data != r_prev);
   assign w_time_sat  = &i_time;
   assign w_limit_in  = CNT_W'(decode_limit(32'(i_max_samples), ADDR_WIDTH));
   assign w_count_inc = r_count + CNT_W'(1);

   // Next-state, record write and status decode.
   always_comb begin
      w_state   = r_state;
      w_limit   = r_limit;
      w_count   = r_count;
      w_wr_en   = 1'b0;
      w_wr_addr = r_wr_addr;
      w_wr_data = r_wr_data;
      w_timeout = r_timeout;

      case (r_state)
         IDLE, DONE: begin
            if (i_arm) begin
               w_state   = ARMED;
               w_count   = '0;
               w_wr_addr = '0;
               w_timeout = 1'b0;
            end
         end
         ARMED: begin
            if (i_abort) begin
               w_state = IDLE;
            end else if (w_trig) begin
               // Record 0 is written on the trigger edge; limit latches here.
               w_wr_en   = 1'b1;
               w_wr_addr = '0;
               w_wr_data = {i_time, i_data};
               w_count   = CNT_W'(1);
               w_limit   = w_limit_in;
               w_state   = (w_limit_in == CNT_W'(1)) ? DONE : CAPTURE;
            end
         end
         CAPTURE: begin
            if (i_abort) begin
               w_state = DONE;
            end else if (w_time_sat) begin
               if (r_count < r_limit) begin
                  w_wr_en   = 1'b1;
                  w_wr_addr = r_count[ADDR_WIDTH-1:0];
                  w_wr_data = {i_time, i_data};
                  w_count   = w_count_inc;
               end
               w_timeout = 1'b1;
               w_state   = DONE;
            end else if (w_changed) begin
               w_wr_en   = 1'b1;
               w_wr_addr = r_count[ADDR_WIDTH-1:0];
               w_wr_data = {i_time, i_data};
               w_count   = w_count_inc;
               if (w_count_inc == r_limit) begin
                  w_state = DONE;
               end
            end
         end
         default: begin
            w_state = IDLE;
         end
      endcase

      w_run  = (w_state == CAPTURE);
      w_busy = (w_state == ARMED) || (w_state == CAPTURE);
      w_done = (w_state == DONE);
   end

   // State and output registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= IDLE;
         r_prev    <= '0;
         r_limit   <= '0;
         r_count   <= '0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_run     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_prev    <= i_data;
         r_limit   <= w_limit;
         r_count   <= w_count;
         r_wr_en   <= w_wr_en;
         r_wr_addr <= w_wr_addr;
         r_wr_data <= w_wr_data;
         r_run     <= w_run;
         r_busy    <= w_busy;
         r_done    <= w_done;
         r_timeout <= w_timeout;
      end
   end

   assign o_run     = r_run;
   assign o_wr_en   = r_wr_en;
   assign o_wr_addr = r_wr_addr;
   assign o_wr_data = r_wr_data;
   assign o_count   = r_count;
   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_timeout = r_timeout;

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: expected RAM writes are queued as stimulus is
// issued; monitors pop and compare whenever a DUT asserts its write strobe.
module tb_capture_sequencer;

   localparam int unsigned CH  = 8;
   localparam int unsigned TL  = 24;
   localparam int unsigned AW  = 10;
   localparam int unsigned TLB = 4;

   typedef struct packed {
      logic [AW-1:0]    addr;
      logic [TL+CH-1:0] data;
   } rec_a_t;

   typedef struct packed {
      logic [AW-1:0]     addr;
      logic [TLB+CH-1:0] data;
   } rec_b_t;

   logic clk = 1'b0;
   logic rst;
   logic arm_a, arm_b, abort;
   logic [CH-1:0] data, mask, value, trig_edge;
   logic [AW:0]   max_samples;

   logic [TL-1:0]  t_a = '0;
   logic [TLB-1:0] t_b = '0;

   logic              run_a, wr_en_a, busy_a, done_a, timeout_a;
   logic [AW-1:0]     wr_addr_a;
   logic [TL+CH-1:0]  wr_data_a;
   logic [AW:0]       count_a;

   logic              run_b, wr_en_b, busy_b, done_b, timeout_b;
   logic [AW-1:0]     wr_addr_b;
   logic [TLB+CH-1:0] wr_data_b;
   logic [AW:0]       count_b;

   rec_a_t q_a[$];
   rec_b_t q_b[$];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Timestamp counters: held at 0 while run is low, saturating otherwise.
   always @(posedge clk) begin
      if (!run_a) t_a <= '0;
      else if (t_a != '1) t_a <= t_a + 1'b1;
   end

   always @(posedge clk) begin
      if (!run_b) t_b <= '0;
      else if (t_b != '1) t_b <= t_b + 1'b1;
   end

   capture_sequencer #(.CHANNELS(CH), .TIME_LENGTH(TL), .ADDR_WIDTH(AW)) u_dut_a (
      .i_clk(clk), .i_rst(rst), .i_arm(arm_a), .i_abort(abort), .i_data(data),
      .i_trig_mask(mask), .i_trig_value(value), .i_trig_edge(trig_edge),
      .i_max_samples(max_samples), .i_time(t_a),
      .o_run(run_a), .o_wr_en(wr_en_a), .o_wr_addr(wr_addr_a), .o_wr_data(wr_data_a),
      .o_count(count_a), .o_busy(busy_a), .o_done(done_a), .o_timeout(timeout_a)
   );

   capture_sequencer #(.CHANNELS(CH), .TIME_LENGTH(TLB), .ADDR_WIDTH(AW)) u_dut_b (
      .i_clk(clk), .i_rst(rst), .i_arm(arm_b), .i_abort(1'b0), .i_data(data),
      .i_trig_mask(mask), .i_trig_value(value), .i_trig_edge(trig_edge),
      .i_max_samples(max_samples), .i_time(t_b),
      .o_run(run_b), .o_wr_en(wr_en_b), .o_wr_addr(wr_addr_b), .o_wr_data(wr_data_b),
      .o_count(count_b), .o_busy(busy_b), .o_done(done_b), .o_timeout(timeout_b)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Expected record uses the timestamp the DUT will sample at the next edge.
   task automatic push_a(input int unsigned addr, input logic [CH-1:0] d);
      q_a.push_back('{addr: AW'(addr), data: {t_a, d}});
   endtask

   task automatic push_b(input int unsigned addr, input logic [TLB-1:0] t, input logic [CH-1:0] d);
      q_b.push_back('{addr: AW'(addr), data: {t, d}});
   endtask

   task automatic mon_a();
      rec_a_t e;
      forever begin
         @(negedge clk);
         if (!rst && wr_en_a) begin
            checks++;
            if (q_a.size() == 0) begin
               errors++;
               $display("FAIL wr_a unexpected addr=%0h data=%0h required=no write", wr_addr_a, wr_data_a);
            end else begin
               e = q_a.pop_front();
               if ({wr_addr_a, wr_data_a} !== e) begin
                  errors++;
                  $display("FAIL wr_a actual addr=%0h data=%0h required addr=%0h data=%0h",
                           wr_addr_a, wr_data_a, e.addr, e.data);
               end
            end
         end
      end
   endtask

   task automatic mon_b();
      rec_b_t e;
      forever begin
         @(negedge clk);
         if (!rst && wr_en_b) begin
            checks++;
            if (q_b.size() == 0) begin
               errors++;
               $display("FAIL wr_b unexpected addr=%0h data=%0h required=no write", wr_addr_b, wr_data_b);
            end else begin
               e = q_b.pop_front();
               if ({wr_addr_b, wr_data_b} !== e) begin
                  errors++;
                  $display("FAIL wr_b actual addr=%0h data=%0h required addr=%0h data=%0h",
                           wr_addr_b, wr_data_b, e.addr, e.data);
               end
            end
         end
      end
   endtask

   // Global guard against a hung run.
   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic seen;
      fork
         mon_a();
         mon_b();
      join_none

      rst = 1'b1; arm_a = 0; arm_b = 0; abort = 0;
      data = '0; mask = '0; value = '0; trig_edge = '0; max_samples = '0;
      repeat (2) step();
      check("reset_outputs_a", 64'({run_a, wr_en_a, busy_a, done_a, timeout_a, wr_addr_a, wr_data_a, count_a}), 64'd0);
      check("reset_outputs_b", 64'({run_b, wr_en_b, busy_b, done_b, timeout_b, count_b}), 64'd0);
      rst = 1'b0;
      step();

      // Free-running trigger: record 0 on the cycle after arm, run follows.
      mask = 8'h00; max_samples = 11'd2; data = 8'h5A;
      step();
      arm_a = 1; step(); arm_a = 0;
      check("t1_armed_busy", 64'(busy_a), 64'd1);
      check("t1_armed_run", 64'(run_a), 64'd0);
      push_a(0, 8'h5A);
      step();
      check("t1_run_after_trig", 64'(run_a), 64'd1);
      data = 8'h5B; push_a(1, 8'h5B);
      step(); step();
      check("t1_done", 64'({done_a, timeout_a, run_a, busy_a}), 64'b1000);
      check("t1_count", 64'(count_a), 64'd2);

      // Edge trigger on channel 0: held level does not fire, 0->1 does.
      mask = 8'h01; value = 8'h01; trig_edge = 8'h01; max_samples = 11'd4;
      data = 8'h01; step();
      arm_a = 1; step(); arm_a = 0;
      repeat (3) step();
      check("t2_held_no_trig", 64'({busy_a, done_a, run_a}), 64'b100);
      check("t2_count_clear", 64'(count_a), 64'd0);
      data = 8'h00; step();
      data = 8'h01; push_a(0, 8'h01); step();
      check("t2_trig_run", 64'(run_a), 64'd1);
      step();
      // Abort two cycles into capture, together with a data change.
      data = 8'h00; abort = 1; step(); abort = 0;
      check("t5_abort_state", 64'({done_a, timeout_a, run_a, busy_a}), 64'b1000);
      check("t5_abort_count", 64'(count_a), 64'd1);
      step();

      // Record limit of 4; limit changes mid-capture must be ignored.
      mask = 8'h00; value = 8'h00; trig_edge = 8'h00; max_samples = 11'd4;
      data = 8'h33; step();
      arm_a = 1; step(); arm_a = 0;
      push_a(0, data); step();
      max_samples = 11'd2;
      for (int i = 1; i <= 5; i++) begin
         step(); step();
         data = ~data;
         if (i <= 3) push_a(i, data);
         step();
      end
      check("t3_done", 64'({done_a, timeout_a, run_a, busy_a}), 64'b1000);
      check("t3_count", 64'(count_a), 64'd4);
      check("t3_last_addr", 64'(wr_addr_a), 64'd3);

      // Narrow timestamp: saturation ends capture with one final record.
      max_samples = 11'd0; data = 8'hC3; step();
      arm_b = 1; step(); arm_b = 0;
      push_b(0, 4'h0, 8'hC3); step();
      push_b(1, 4'hF, 8'hC3);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step();
         seen = done_b;
      end
      check("t4_done_seen", 64'(seen), 64'd1);
      check("t4_status", 64'({done_b, timeout_b, run_b, busy_b}), 64'b1100);
      check("t4_count", 64'(count_b), 64'd2);

      // Asynchronous reset right after a write, then re-arm with abort.
      max_samples = 11'd0; data = 8'h10; step();
      arm_a = 1; step(); arm_a = 0;
      push_a(0, 8'h10); step();
      data = 8'h11; push_a(1, 8'h11); step();
      @(negedge clk); #1;
      rst = 1'b1; #1;
      check("t6_async_reset", 64'({run_a, wr_en_a, busy_a, done_a, timeout_a, wr_addr_a, wr_data_a, count_a}), 64'd0);
      step(); step();
      rst = 1'b0;
      data = 8'h22; step();
      arm_a = 1; abort = 1; step(); arm_a = 0; abort = 0;
      check("t6_arm_wins", 64'({busy_a, done_a}), 64'b10);
      push_a(0, 8'h22); step();
      check("t6_rearm_addr", 64'(wr_addr_a), 64'd0);
      check("t6_rearm_count", 64'(count_a), 64'd1);
      abort = 1; step(); abort = 0;
      check("t6_abort_done", 64'({done_a, timeout_a}), 64'b10);

      step(); step();
      check("queue_a_drained", 64'(q_a.size()), 64'd0);
      check("queue_b_drained", 64'(q_b.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
